rect_fill_engine: RTL

Drawing engine upstream of the 640x480 VGA scan-out. It fills an axis-aligned rectangle of one 8-bit colour (rrr_ggg_bb) into the pixel RAM through the RAM's write port. Each write uses the same 9-bit row / 10-bit column addressing that the scan-out uses on the read side. It is driven by a start/busy/done command handshake from the CPU side and back-pressured by the RAM port's ready.

---
 rtl/rect_fill_engine_pkg.sv | 32 +++
 rtl/rect_fill_engine_if.sv | 33 +++
 rtl/rect_normalize.sv | 44 ++++
 rtl/rect_fill_engine.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rect_fill_engine_pkg.sv
// Shared definitions for the rectangle fill engine and the VGA scan-out side:
// screen geometry, address/colour widths, engine states and clip helpers.
package rect_fill_engine_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;
  localparam int RGB_W    = 8;
  localparam int CNT_W    = 19;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_FILL   = 2'd2,
    ST_FINISH = 2'd3
  } fill_state_e;

  // Saturate a column coordinate to the last visible column.
  function automatic logic [COL_W-1:0] clip_col(input logic [COL_W-1:0] v);
    return (v > COL_MAX) ? COL_MAX : v;
  endfunction

  // Saturate a row coordinate to the last visible row.
  function automatic logic [ROW_W-1:0] clip_row(input logic [ROW_W-1:0] v);
    return (v > ROW_MAX) ? ROW_MAX : v;
  endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command handshake plus pixel-RAM write port of the fill engine.
// master = CPU / RAM side, slave = the engine.
interface rect_fill_engine_if;
  import rect_fill_engine_pkg::*;

  logic             start;
  logic             abort;
  logic [COL_W-1:0] x0;
  logic [COL_W-1:0] x1;
  logic [ROW_W-1:0] y0;
  logic [ROW_W-1:0] y1;
  logic [RGB_W-1:0] color;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pixel_count;
  logic             wr_en;
  logic             wr_ready;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [RGB_W-1:0] wr_data;

  modport master (
    output start, abort, x0, x1, y0, y1, color, wr_ready,
    input  busy, done, aborted, pixel_count, wr_en, wr_row, wr_col, wr_data
  );

  modport slave (
    input  start, abort, x0, x1, y0, y1, color, wr_ready,
    output busy, done, aborted, pixel_count, wr_en, wr_row, wr_col, wr_data
  );

endinterface

// File: rtl/rect_normalize.sv
// Combinational corner ordering and clipping of a rectangle to the visible
// screen. Reusable by any engine that walks an axis-aligned region.
module rect_normalize
  import rect_fill_engine_pkg::*;
(
  input  logic [COL_W-1:0] i_x0,
  input  logic [COL_W-1:0] i_x1,
  input  logic [ROW_W-1:0] i_y0,
  input  logic [ROW_W-1:0] i_y1,
  output logic [COL_W-1:0] o_xl,
  output logic [COL_W-1:0] o_xr,
  output logic [ROW_W-1:0] o_yt,
  output logic [ROW_W-1:0] o_yb
);

  logic [COL_W-1:0] w_xmin;
  logic [COL_W-1:0] w_xmax;
  logic [ROW_W-1:0] w_ymin;
  logic [ROW_W-1:0] w_ymax;

  // Order each corner pair into min/max.
  always_comb begin
    if (i_x0 <= i_x1) begin
      w_xmin = i_x0;
      w_xmax = i_x1;
    end else begin
      w_xmin = i_x1;
      w_xmax = i_x0;
    end
    if (i_y0 <= i_y1) begin
      w_ymin = i_y0;
      w_ymax = i_y1;
    end else begin
      w_ymin = i_y1;
      w_ymax = i_y0;
    end
  end

  assign o_xl = clip_col(w_xmin);
  assign o_xr = clip_col(w_xmax);
  assign o_yt = clip_row(w_ymin);
  assign o_yb = clip_row(w_ymax);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: walks the clipped rectangle row by row and issues
// one pixel write per accepted RAM handshake. All outputs are registered.
module rect_fill_engine
  import rect_fill_engine_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  rect_fill_engine_if.slave  bus
);

  fill_state_e      r_state,   w_state_nxt;
  logic [COL_W-1:0] r_xl,      w_xl_nxt;
  logic [COL_W-1:0] r_xr,      w_xr_nxt;
  logic [ROW_W-1:0] r_yt,      w_yt_nxt;
  logic [ROW_W-1:0] r_yb,      w_yb_nxt;
  logic [RGB_W-1:0] r_color,   w_color_nxt;
  logic [COL_W-1:0] r_col,     w_col_nxt;
  logic [ROW_W-1:0] r_row,     w_row_nxt;
  logic             r_wr_en,   w_wr_en_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;
  logic             r_aborted, w_aborted_nxt;
  logic [CNT_W-1:0] r_count,   w_count_nxt;

  logic [COL_W-1:0] w_norm_xl;
  logic [COL_W-1:0] w_norm_xr;
  logic [ROW_W-1:0] w_norm_yt;
  logic [ROW_W-1:0] w_norm_yb;
  logic             w_accept;
  logic             w_row_end;
  logic             w_last;

  rect_normalize u_norm (
    .i_x0 (bus.x0),
    .i_x1 (bus.x1),
    .i_y0 (bus.y0),
    .i_y1 (bus.y1),
    .o_xl (w_norm_xl),
    .o_xr (w_norm_xr),
    .o_yt (w_norm_yt),
    .o_yb (w_norm_yb)
  );

  assign w_accept  = r_wr_en & bus.wr_ready;
  assign w_row_end = (r_col == r_xr);
  assign w_last    = w_row_end && (r_row == r_yb);

  // Next-state and next-output logic of the fill sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_xl_nxt      = r_xl;
    w_xr_nxt      = r_xr;
    w_yt_nxt      = r_yt;
    w_yb_nxt      = r_yb;
    w_color_nxt   = r_color;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_wr_en_nxt   = r_wr_en;
    w_busy_nxt    = r_busy;
    w_count_nxt   = r_count;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          // Corners are normalised on the way in so SETUP only loads the walker.
          w_state_nxt = ST_SETUP;
          w_busy_nxt  = 1'b1;
          w_xl_nxt    = w_norm_xl;
          w_xr_nxt    = w_norm_xr;
          w_yt_nxt    = w_norm_yt;
          w_yb_nxt    = w_norm_yb;
          w_color_nxt = bus.color;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (bus.abort) begin
          w_state_nxt   = ST_IDLE;
          w_busy_nxt    = 1'b0;
          w_aborted_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_FILL;
          w_count_nxt = {CNT_W{1'b0}};
          w_col_nxt   = r_xl;
          w_row_nxt   = r_yt;
        end
      end
      ST_FILL: begin
        if (bus.abort) begin
          // A write completing alongside the abort still counts.
          w_state_nxt   = ST_IDLE;
          w_wr_en_nxt   = 1'b0;
          w_busy_nxt    = 1'b0;
          w_aborted_nxt = 1'b1;
          if (w_accept) begin
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            w_count_nxt = r_count;
          end
        end else if (!r_wr_en) begin
          w_wr_en_nxt = 1'b1;
        end else if (w_accept) begin
          w_count_nxt = r_count + CNT_W'(1);
          if (w_last) begin
            w_state_nxt = ST_FINISH;
            w_wr_en_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (w_row_end) begin
            w_col_nxt = r_xl;
            w_row_nxt = r_row + ROW_W'(1);
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end else begin
          // Stalled: request, address and data stay put.
          w_wr_en_nxt = r_wr_en;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wr_en_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= ST_IDLE;
      r_xl      <= {COL_W{1'b0}};
      r_xr      <= {COL_W{1'b0}};
      r_yt      <= {ROW_W{1'b0}};
      r_yb      <= {ROW_W{1'b0}};
      r_color   <= {RGB_W{1'b0}};
      r_col     <= {COL_W{1'b0}};
      r_row     <= {ROW_W{1'b0}};
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_count   <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_xl      <= w_xl_nxt;
      r_xr      <= w_xr_nxt;
      r_yt      <= w_yt_nxt;
      r_yb      <= w_yb_nxt;
      r_color   <= w_color_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;
  assign bus.pixel_count = r_count;
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_row      = r_row;
  assign bus.wr_col      = r_col;
  assign bus.wr_data     = r_color;

endmodule
